// File: rtl/reg_file_write_arbiter.sv
// Round-robin arbiter feeding the register file's two write ports; grants up to two
// distinct-index requests per cycle. Define REG_FILE_R0_ZERO_EN to discard writes to register 0.
module reg_file_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 3
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [5*NUM_REQ-1:0]  req_index,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  write1,
  output logic [4:0]            write_index1,
  output logic [31:0]           write_data1,
  output logic                  write2,
  output logic [4:0]            write_index2,
  output logic [31:0]           write_data2,
  output logic [1:0]            grant_count
);

  logic [PTR_W-1:0]   rr_q, rr_d, last_sel;
  logic               write1_q, write1_d, write2_q, write2_d;
  logic [4:0]         write_index1_q, write_index1_d, write_index2_q, write_index2_d;
  logic [31:0]        write_data1_q, write_data1_d, write_data2_q, write_data2_d;
  logic [1:0]         grant_count_q, grant_count_d;

  logic               a_found, b_found, a_wr, b_wr;
  logic [PTR_W-1:0]   a_sel, b_sel;
  logic [4:0]         a_index, b_index;
  logic [31:0]        a_data, b_data;
  logic [NUM_REQ-1:0] grant;

  // Position of requester r in the scan that starts at ptr.
  function automatic int scan_rank(input int r, input logic [PTR_W-1:0] ptr);
    int d;
    d = r - int'(ptr);
    if (d < 0) d = d + NUM_REQ;
    return d;
  endfunction

  always_comb begin
    a_found = 1'b0;
    b_found = 1'b0;
    a_sel   = '0;
    b_sel   = '0;
    a_index = '0;
    b_index = '0;
    a_data  = '0;
    b_data  = '0;
    grant   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (scan_rank(r, rr_q) == k && req_valid[r]) begin
          if (!a_found) begin
            a_found  = 1'b1;
            a_sel    = PTR_W'(r);
            a_index  = req_index[5*r +: 5];
            a_data   = req_data[32*r +: 32];
            grant[r] = 1'b1;
          end else if (!b_found && req_index[5*r +: 5] != a_index) begin
            b_found  = 1'b1;
            b_sel    = PTR_W'(r);
            b_index  = req_index[5*r +: 5];
            b_data   = req_data[32*r +: 32];
            grant[r] = 1'b1;
          end
        end
      end
    end
  end

`ifdef REG_FILE_R0_ZERO_EN
  // Index-0 grants still consume the slot and move the pointer, but never write.
  assign a_wr = a_found && (a_index != 5'd0);
  assign b_wr = b_found && (b_index != 5'd0);
`else
  assign a_wr = a_found;
  assign b_wr = b_found;
`endif

  assign req_ready = clear ? '0 : grant;

  always_comb begin
    last_sel = b_found ? b_sel : a_sel;
    rr_d     = rr_q;
    if (a_found) begin
      rr_d = (last_sel == PTR_W'(NUM_REQ - 1)) ? '0 : last_sel + 1'b1;
    end
    write1_d       = a_wr;
    write_index1_d = a_wr ? a_index : '0;
    write_data1_d  = a_wr ? a_data  : '0;
    write2_d       = b_wr;
    write_index2_d = b_wr ? b_index : '0;
    write_data2_d  = b_wr ? b_data  : '0;
    grant_count_d  = {1'b0, a_wr} + {1'b0, b_wr};
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      rr_q           <= '0;
      write1_q       <= 1'b0;
      write_index1_q <= '0;
      write_data1_q  <= '0;
      write2_q       <= 1'b0;
      write_index2_q <= '0;
      write_data2_q  <= '0;
      grant_count_q  <= '0;
    end else begin
      rr_q           <= rr_d;
      write1_q       <= write1_d;
      write_index1_q <= write_index1_d;
      write_data1_q  <= write_data1_d;
      write2_q       <= write2_d;
      write_index2_q <= write_index2_d;
      write_data2_q  <= write_data2_d;
      grant_count_q  <= grant_count_d;
    end
  end

  assign write1       = write1_q;
  assign write_index1 = write_index1_q;
  assign write_data1  = write_data1_q;
  assign write2       = write2_q;
  assign write_index2 = write_index2_q;
  assign write_data2  = write_data2_q;
  assign grant_count  = grant_count_q;

endmodule
